// File: rtl/palette_mapper_pkg.sv
// Shared constants and types for the palette lookup stage: default widths,
// pipeline depth, write-buffer FSM encoding and the RGB565 -> VGA reduction.
package palette_mapper_pkg;

    localparam int IDX_W      = 9;   // {palette[4:0], color[3:0]}
    localparam int COL_W      = 16;  // RGB565
    localparam int PIPE_DEPTH = 2;   // RAM read stage + output stage

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } buf_state_e;

    // Keep the top bits of each RGB565 field: {r[2:0], g[2:0], b[1:0]}.
    function automatic logic [7:0] rgb565_to_vga(input logic [15:0] c);
        return {c[15:13], c[10:8], c[4:3]};
    endfunction

endpackage

// File: rtl/palette_mapper_if.sv
// CPU-side palette write bus. The master drives address/data/strobes, the
// palette mapper (slave) reports whether its one-entry write buffer is free.
interface palette_mapper_if #(
    parameter int IDX_W = palette_mapper_pkg::IDX_W,
    parameter int COL_W = palette_mapper_pkg::COL_W
) ();
    import palette_mapper_pkg::*;

    logic [IDX_W-1:0] mem_addr;
    logic [COL_W-1:0] write_data;
    logic             mem_write;
    logic             mem_enable;
    logic             wr_ready;

    modport master (
        output mem_addr,
        output write_data,
        output mem_write,
        output mem_enable,
        input  wr_ready
    );

    modport slave (
        input  mem_addr,
        input  write_data,
        input  mem_write,
        input  mem_enable,
        output wr_ready
    );

endinterface

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM: one write port, one registered read port.
// No reset, so it maps onto a block RAM; contents are undefined until written.
module palette_ram #(
    parameter int IDX_W = palette_mapper_pkg::IDX_W,
    parameter int COL_W = palette_mapper_pkg::COL_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [COL_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [COL_W-1:0] rdata
);
    import palette_mapper_pkg::*;

    logic [COL_W-1:0] mem_q [0:(1<<IDX_W)-1];
    logic [COL_W-1:0] rd_data_q;

    // Write and registered read; a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rd_data_q <= mem_q[raddr];
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/palette_mapper.sv
// Palette lookup stage: index -> RAM read (stage 1) -> VGA color register
// (stage 2), with syncs delayed to match. CPU writes go through a one-entry
// buffer that only commits to RAM while the beam is outside the active area.
module palette_mapper #(
    parameter int IDX_W = palette_mapper_pkg::IDX_W,
    parameter int COL_W = palette_mapper_pkg::COL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  index_in,
    input  logic              pix_valid,
    input  logic              hsync_in,
    input  logic              vsync_in,
    palette_mapper_if.slave   cpu,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              hsync_out,
    output logic              vsync_out
);
    import palette_mapper_pkg::*;

    buf_state_e        state_q, state_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [COL_W-1:0]  data_q, data_d;
    logic              ram_we;
    logic [COL_W-1:0]  ram_rdata;

    logic [PIPE_DEPTH-1:0] valid_q, valid_d;
    logic [PIPE_DEPTH-1:0] hs_q, hs_d;
    logic [PIPE_DEPTH-1:0] vs_q, vs_d;
    logic [7:0]            vga_q, vga_d;

    palette_ram #(
        .IDX_W (IDX_W),
        .COL_W (COL_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (data_q),
        .raddr (index_in),
        .rdata (ram_rdata)
    );

    // Write buffer: accept into PEND when free, commit on the first blank cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu.mem_enable && cpu.mem_write) begin
                    addr_d  = cpu.mem_addr;
                    data_d  = cpu.write_data;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!pix_valid) begin
                    ram_we  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu.wr_ready = (state_q == ST_IDLE);

    // Write buffer state; reset drops any pending entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Shift valid and syncs along the pipeline; stage 2 captures the RAM word.
    always_comb begin
        valid_d = {valid_q[PIPE_DEPTH-2:0], pix_valid};
        hs_d    = {hs_q[PIPE_DEPTH-2:0], hsync_in};
        vs_d    = {vs_q[PIPE_DEPTH-2:0], vsync_in};
        vga_d   = rgb565_to_vga(ram_rdata[15:0]);
    end

    // Pipeline registers; syncs idle high (inactive) in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            hs_q    <= '1;
            vs_q    <= '1;
            vga_q   <= '0;
        end else begin
            valid_q <= valid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vga_q   <= vga_d;
        end
    end

    assign red       = valid_q[PIPE_DEPTH-1] ? vga_q[7:5] : 3'd0;
    assign green     = valid_q[PIPE_DEPTH-1] ? vga_q[4:2] : 3'd0;
    assign blue      = valid_q[PIPE_DEPTH-1] ? vga_q[1:0] : 2'd0;
    assign hsync_out = hs_q[PIPE_DEPTH-1];
    assign vsync_out = vs_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_palette_mapper.sv
// Directed bench for palette_mapper: buffered CPU writes, blanking-only
// commits, two-cycle color/sync latency and reset behaviour.
module tb_palette_mapper;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] index_in;
    logic       pix_valid;
    logic       hsync_in;
    logic       vsync_in;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       hsync_out;
    logic       vsync_out;

    int tests = 0;
    int fails = 0;

    palette_mapper_if #(.IDX_W(9), .COL_W(16)) cpu_if ();

    palette_mapper dut (
        .clk       (clk),
        .rst       (rst),
        .index_in  (index_in),
        .pix_valid (pix_valid),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .cpu       (cpu_if),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_color(input string tag, input logic [2:0] r, input logic [2:0] g,
                             input logic [1:0] b);
        chk(tag, {24'd0, red, green, blue}, {24'd0, r, g, b});
    endtask

    // Present a write for one edge, then release the strobes.
    task automatic cpu_write(input logic [8:0] a, input logic [15:0] d);
        $display("[TB] cpu write addr=%03h data=%04h wr_ready=%0b", a, d, cpu_if.wr_ready);
        cpu_if.mem_addr   = a;
        cpu_if.write_data = d;
        cpu_if.mem_enable = 1'b1;
        cpu_if.mem_write  = 1'b1;
        step();
        cpu_if.mem_enable = 1'b0;
        cpu_if.mem_write  = 1'b0;
    endtask

    initial begin
        rst               = 1'b0;
        index_in          = 9'd0;
        pix_valid         = 1'b0;
        hsync_in          = 1'b1;
        vsync_in          = 1'b1;
        cpu_if.mem_addr   = 9'd0;
        cpu_if.write_data = 16'd0;
        cpu_if.mem_write  = 1'b0;
        cpu_if.mem_enable = 1'b0;

        // Reset state
        step(); step();
        chk("rst_wr_ready", {31'd0, cpu_if.wr_ready}, 32'd1);
        chk_color("rst_color", 3'd0, 3'd0, 2'd0);
        chk("rst_hsync", {31'd0, hsync_out}, 32'd1);
        chk("rst_vsync", {31'd0, vsync_out}, 32'd1);
        rst = 1'b1;
        step();

        // Write during blanking: one cycle busy, then free
        cpu_write(9'h015, 16'hF800);
        chk("blank_wr_busy", {31'd0, cpu_if.wr_ready}, 32'd0);
        step();
        chk("blank_wr_free", {31'd0, cpu_if.wr_ready}, 32'd1);
        index_in  = 9'h015;
        pix_valid = 1'b1;
        step();
        chk_color("red_latency1", 3'd0, 3'd0, 2'd0);
        step();
        chk_color("red_entry", 3'd7, 3'd0, 2'd0);
        $display("[TB] read idx=015 color=%0d/%0d/%0d", red, green, blue);

        // Blanked pixels are black whatever the index
        pix_valid = 1'b0;
        step(); step();
        chk_color("blank_color", 3'd0, 3'd0, 2'd0);

        // Write during active video: held off for 100 cycles
        pix_valid = 1'b1;
        step(); step();
        chk_color("active_pre", 3'd7, 3'd0, 2'd0);
        cpu_write(9'h015, 16'h07E0);
        for (int c = 0; c < 100; c++) begin
            chk("active_busy", {31'd0, cpu_if.wr_ready}, 32'd0);
            chk_color("active_hold", 3'd7, 3'd0, 2'd0);
            step();
        end
        pix_valid = 1'b0;
        step();
        chk("active_commit_free", {31'd0, cpu_if.wr_ready}, 32'd1);
        pix_valid = 1'b1;
        step(); step();
        chk_color("green_entry", 3'd0, 3'd7, 2'd0);
        $display("[TB] read idx=015 color=%0d/%0d/%0d", red, green, blue);

        // Second write while pending is dropped
        cpu_write(9'h020, 16'h001F);
        chk("pend_busy", {31'd0, cpu_if.wr_ready}, 32'd0);
        cpu_write(9'h020, 16'hFFFF);
        step(); step();
        pix_valid = 1'b0;
        step();
        chk("pend_commit_free", {31'd0, cpu_if.wr_ready}, 32'd1);
        step();
        chk("pend_no_requeue", {31'd0, cpu_if.wr_ready}, 32'd1);
        index_in  = 9'h020;
        pix_valid = 1'b1;
        step(); step();
        chk_color("first_data_kept", 3'd0, 3'd0, 2'd3);
        $display("[TB] read idx=020 color=%0d/%0d/%0d", red, green, blue);

        // 96-cycle hsync pulse, short vsync pulse, both delayed by 2
        pix_valid = 1'b0;
        step(); step();
        for (int c = 0; c < 100; c++) begin
            hsync_in = (c < 96) ? 1'b0 : 1'b1;
            vsync_in = (c >= 10 && c < 12) ? 1'b0 : 1'b1;
            step();
            chk("hsync_delay", {31'd0, hsync_out}, ((c >= 1 && c <= 96) ? 32'd0 : 32'd1));
            chk("vsync_delay", {31'd0, vsync_out}, ((c >= 11 && c <= 12) ? 32'd0 : 32'd1));
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;

        // Reset while a write is pending
        index_in  = 9'h015;
        pix_valid = 1'b1;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        cpu_write(9'h015, 16'h1234);
        step();
        chk("prerst_busy", {31'd0, cpu_if.wr_ready}, 32'd0);
        chk_color("prerst_color", 3'd0, 3'd7, 2'd0);
        chk("prerst_hsync", {31'd0, hsync_out}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_wr_ready", {31'd0, cpu_if.wr_ready}, 32'd1);
        chk("midrst_hsync", {31'd0, hsync_out}, 32'd1);
        chk("midrst_vsync", {31'd0, vsync_out}, 32'd1);
        chk_color("midrst_color", 3'd0, 3'd0, 2'd0);
        pix_valid = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        step(); step();
        rst       = 1'b1;
        pix_valid = 1'b1;
        step();
        chk_color("postrst_latency1", 3'd0, 3'd0, 2'd0);
        step();
        chk_color("postrst_old_kept", 3'd0, 3'd7, 2'd0);
        chk("postrst_wr_ready", {31'd0, cpu_if.wr_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
